// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared constants and Gray-code helpers for the async FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;
    localparam int GRAY_W  = 32;

    // Gray coding is width-independent under zero extension, so callers
    // cast their narrow pointer up to GRAY_W and the result back down.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// sync_ff : multi-stage flop chain for bringing a bus into the local clock
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] r_chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fifo_ptr_ctl.sv
// ============================================================================
// fifo_ptr_ctl : one-side pointer controller (write or read) of an async FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_ptr_ctl
    import fifo_pkg::*;
#(
    parameter int ptr_w       = 3,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int THRESH      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ptr_w:0]   remote_g,
    output logic [ptr_w-1:0] addr,
    output logic [ptr_w:0]   ptr_g,
    output logic             stat,
    output logic             almost,
    output logic [ptr_w:0]   level,
    output logic             err
);

    localparam int PW = ptr_w + 1;
    localparam logic [ptr_w:0] c_full_mask = PW'(3) << (ptr_w - 1);
    localparam logic [ptr_w:0] c_thresh    = PW'(THRESH);

    logic [ptr_w:0] r_ptr_b;
    logic [ptr_w:0] r_ptr_g;
    logic           r_err;
    logic [ptr_w:0] w_rsync_g;
    logic [ptr_w:0] w_rsync_b;
    logic [ptr_w:0] w_ptr_b_nxt;
    logic [ptr_w:0] w_level;
    logic           w_stat;
    logic           w_advance;

    sync_ff #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (remote_g),
        .q   (w_rsync_g)
    );

    assign w_rsync_b   = PW'(gray2bin(GRAY_W'(w_rsync_g)));
    assign w_ptr_b_nxt = r_ptr_b + PW'(1);
    assign w_advance   = en & ~w_stat;

    // Gray value is registered alongside the binary one so the exported
    // pointer is a clean flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr_b <= '0;
            r_ptr_g <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_advance) begin
                r_ptr_b <= w_ptr_b_nxt;
                r_ptr_g <= PW'(bin2gray(GRAY_W'(w_ptr_b_nxt)));
            end
            if (en && w_stat) begin
                r_err <= 1'b1;
            end
        end
    end

    generate
        if (MODE == MODE_WR) begin : g_wr
            // Full when local and remote differ only in the top two Gray bits.
            assign w_stat  = (r_ptr_g == (w_rsync_g ^ c_full_mask));
            assign w_level = r_ptr_b - w_rsync_b;
            assign almost  = (w_level >= c_thresh);
        end else begin : g_rd
            assign w_stat  = (r_ptr_g == w_rsync_g);
            assign w_level = w_rsync_b - r_ptr_b;
            assign almost  = (w_level <= c_thresh);
        end
    endgenerate

    assign addr  = r_ptr_b[ptr_w-1:0];
    assign ptr_g = r_ptr_g;
    assign stat  = w_stat;
    assign level = w_level;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ptr_ctl.sv
// ============================================================================
// tb_fifo_ptr_ctl : vector-table bench driving a write-side and a read-side
// instance of fifo_ptr_ctl side by side
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_ptr_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_w = 1'b0, en_r = 1'b0;
    logic [3:0] rg_w = '0, rg_r = '0;
    logic [2:0] addr_w, addr_r;
    logic [3:0] ptrg_w, ptrg_r, lvl_w, lvl_r;
    logic       stat_w, stat_r, alm_w, alm_r, err_w, err_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctl #(.ptr_w(3), .MODE(0), .SYNC_STAGES(2), .THRESH(6)) dut_wr (
        .clk(clk), .rst(rst), .en(en_w), .remote_g(rg_w), .addr(addr_w),
        .ptr_g(ptrg_w), .stat(stat_w), .almost(alm_w), .level(lvl_w), .err(err_w));

    fifo_ptr_ctl #(.ptr_w(3), .MODE(1), .SYNC_STAGES(2), .THRESH(6)) dut_rd (
        .clk(clk), .rst(rst), .en(en_r), .remote_g(rg_r), .addr(addr_r),
        .ptr_g(ptrg_r), .stat(stat_r), .almost(alm_r), .level(lvl_r), .err(err_r));

    typedef struct {
        string      nm;
        logic       rst;
        logic       en_w;
        logic [3:0] rg_w;
        logic       en_r;
        logic [3:0] rg_r;
        logic [2:0] a_w;
        logic [3:0] g_w;
        logic       s_w, al_w;
        logic [3:0] l_w;
        logic       e_w;
        logic [2:0] a_r;
        logic [3:0] g_r;
        logic       s_r, al_r;
        logic [3:0] l_r;
        logic       e_r;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    task automatic add(string nm, logic r, logic enw, logic [3:0] rgw, logic enr, logic [3:0] rgr,
                       logic [2:0] aw, logic [3:0] gw, logic sw, logic alw, logic [3:0] lw, logic ew,
                       logic [2:0] ar, logic [3:0] gr, logic sr, logic alr, logic [3:0] lr, logic er);
        vec_t v;
        v.nm = nm; v.rst = r; v.en_w = enw; v.rg_w = rgw; v.en_r = enr; v.rg_r = rgr;
        v.a_w = aw; v.g_w = gw; v.s_w = sw; v.al_w = alw; v.l_w = lw; v.e_w = ew;
        v.a_r = ar; v.g_r = gr; v.s_r = sr; v.al_r = alr; v.l_r = lr; v.e_r = er;
        tbl.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic cmp(vec_t e);
        chk({e.nm, ".addr_w"},  32'(addr_w), 32'(e.a_w));
        chk({e.nm, ".ptrg_w"},  32'(ptrg_w), 32'(e.g_w));
        chk({e.nm, ".stat_w"},  32'(stat_w), 32'(e.s_w));
        chk({e.nm, ".alm_w"},   32'(alm_w),  32'(e.al_w));
        chk({e.nm, ".level_w"}, 32'(lvl_w),  32'(e.l_w));
        chk({e.nm, ".err_w"},   32'(err_w),  32'(e.e_w));
        chk({e.nm, ".addr_r"},  32'(addr_r), 32'(e.a_r));
        chk({e.nm, ".ptrg_r"},  32'(ptrg_r), 32'(e.g_r));
        chk({e.nm, ".stat_r"},  32'(stat_r), 32'(e.s_r));
        chk({e.nm, ".alm_r"},   32'(alm_r),  32'(e.al_r));
        chk({e.nm, ".level_r"}, 32'(lvl_r),  32'(e.l_r));
        chk({e.nm, ".err_r"},   32'(err_r),  32'(e.e_r));
    endtask

    function automatic logic [3:0] g4(int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        int   lv;

        // reset held with en toggling and a nonzero remote pointer
        add("rst0", 0, 1, 4'b0101, 1, 4'b0101, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add("rst1", 0, 0, 4'b0101, 0, 4'b0101, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add("rst2", 0, 1, 4'b0101, 1, 4'b0101, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        // write side fills to full, then overflows twice
        add("fill1",  1, 1, 0, 0, 0, 1, 4'b0001, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        add("fill2",  1, 1, 0, 0, 0, 2, 4'b0011, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0);
        add("fill3",  1, 1, 0, 0, 0, 3, 4'b0010, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0);
        add("fill4",  1, 1, 0, 0, 0, 4, 4'b0110, 0, 0, 4, 0, 0, 0, 1, 1, 0, 0);
        add("fill5",  1, 1, 0, 0, 0, 5, 4'b0111, 0, 0, 5, 0, 0, 0, 1, 1, 0, 0);
        add("fill6",  1, 1, 0, 0, 0, 6, 4'b0101, 0, 1, 6, 0, 0, 0, 1, 1, 0, 0);
        add("fill7",  1, 1, 0, 0, 0, 7, 4'b0100, 0, 1, 7, 0, 0, 0, 1, 1, 0, 0);
        add("fill8",  1, 1, 0, 0, 0, 0, 4'b1100, 1, 1, 8, 0, 0, 0, 1, 1, 0, 0);
        add("fill9",  1, 1, 0, 0, 0, 0, 4'b1100, 1, 1, 8, 1, 0, 0, 1, 1, 0, 0);
        add("fill10", 1, 1, 0, 0, 0, 0, 4'b1100, 1, 1, 8, 1, 0, 0, 1, 1, 0, 0);
        // read side: remote moves to binary 2, two pops, then underflow
        add("drst",   0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add("dsync1", 1, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add("dsync2", 1, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 2, 0);
        add("dpop1",  1, 0, 0, 1, 4'b0011, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 1, 1, 0);
        add("dpop2",  1, 0, 0, 1, 4'b0011, 0, 0, 0, 0, 0, 0, 2, 4'b0011, 1, 1, 0, 0);
        add("dunder", 1, 0, 0, 1, 4'b0011, 0, 0, 0, 0, 0, 0, 2, 4'b0011, 1, 1, 0, 1);
        add("dhold",  1, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0, 2, 4'b0011, 1, 1, 0, 1);
        // write side wraps while the remote pointer trails one entry behind
        add("wrst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        for (int t = 0; t < 16; t++) begin
            lv = (t + 1 < 3) ? t + 1 : 3;
            add($sformatf("wrap%0d", t + 1), 1, 1, g4((t > 0) ? t - 1 : 0), 0, 0,
                3'((t + 1) % 8), g4((t + 1) % 16), 0, 0, 4'(lv), 0,
                0, 4'b0000, 1, 1, 0, 0);
        end
        // level 5 on the write side (below threshold), level 2 on the read side
        add("arst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add("alm1", 1, 1, 0, 0, 4'b0011, 1, 4'b0001, 0, 0, 1, 0, 0, 4'b0000, 1, 1, 0, 0);
        add("alm2", 1, 1, 0, 0, 4'b0011, 2, 4'b0011, 0, 0, 2, 0, 0, 4'b0000, 0, 1, 2, 0);
        add("alm3", 1, 1, 0, 0, 4'b0011, 3, 4'b0010, 0, 0, 3, 0, 0, 4'b0000, 0, 1, 2, 0);
        add("alm4", 1, 1, 0, 0, 4'b0011, 4, 4'b0110, 0, 0, 4, 0, 0, 4'b0000, 0, 1, 2, 0);
        add("alm5", 1, 1, 0, 0, 4'b0011, 5, 4'b0111, 0, 0, 5, 0, 0, 4'b0000, 0, 1, 2, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst  = tbl[i].rst;
            en_w = tbl[i].en_w;
            rg_w = tbl[i].rg_w;
            en_r = tbl[i].en_r;
            rg_r = tbl[i].rg_r;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            cmp(e);
        end

        // asynchronous reset pulse mid-operation, checked before any edge
        rst = 1'b0;
        #1;
        chk("arst.ptrg_w",  32'(ptrg_w), 0);
        chk("arst.addr_w",  32'(addr_w), 0);
        chk("arst.level_w", 32'(lvl_w),  0);
        chk("arst.stat_w",  32'(stat_w), 0);
        chk("arst.alm_w",   32'(alm_w),  0);
        chk("arst.stat_r",  32'(stat_r), 1);
        chk("arst.level_r", 32'(lvl_r),  0);
        chk("arst.alm_r",   32'(alm_r),  1);
        @(negedge clk);
        rst  = 1'b1;
        en_w = 1'b1;
        en_r = 1'b0;
        rg_r = 4'b0000;
        @(posedge clk);
        #1;
        chk("resume.ptrg_w",  32'(ptrg_w), 32'b0001);
        chk("resume.addr_w",  32'(addr_w), 1);
        chk("resume.level_w", 32'(lvl_w),  1);
        chk("resume.stat_w",  32'(stat_w), 0);
        chk("resume.stat_r",  32'(stat_r), 1);
        chk("resume.level_r", 32'(lvl_r),  0);
        en_w = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
